izh_neuron_fsm: RTL and testbench



---
 rtl/neuron_pkg.sv | 50 +++++
 rtl/mult18s_reg.sv | 22 ++
 rtl/izh_neuron_fsm.sv | 157 +++++++++++++++
 tb/tb_izh_neuron_fsm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Q-format widths, FSM state encoding, default Izhikevich constants and
// saturation helpers shared by the membrane-update datapath.
package neuron_pkg;

  localparam int Q_W    = 18;
  localparam int FRAC_W = 10;
  localparam int ACC_W  = 28;
  localparam int PROD_W = 2 * Q_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL_T  = 3'd1,
    ST_MUL_V  = 3'd2,
    ST_MUL_B  = 3'd3,
    ST_MUL_A  = 3'd4,
    ST_UPDATE = 3'd5
  } state_e;

  localparam logic signed [Q_W-1:0]   DEF_K_004 = 18'sd41;
  localparam logic signed [Q_W-1:0]   DEF_K_A   = 18'sd20;
  localparam logic signed [Q_W-1:0]   DEF_K_B   = 18'sd205;
  localparam logic signed [Q_W-1:0]   DEF_V_C   = -18'sd66560;
  localparam logic signed [Q_W-1:0]   DEF_U_D   = 18'sd8192;
  localparam logic signed [Q_W-1:0]   DEF_V_TH  = 18'sd30720;
  localparam logic signed [ACC_W-1:0] DEF_K_140 = 28'sd143360;
  // Rest value of u is b*c taken as the exact product -13.0, not the Q8.10 multiply.
  localparam logic signed [Q_W-1:0]   U_RST     = -18'sd13312;

  localparam logic signed [Q_W-1:0]   Q_MAX     = 18'sh1FFFF;
  localparam logic signed [Q_W-1:0]   Q_MIN     = 18'sh20000;
  localparam logic signed [ACC_W-1:0] ACC_QMAX  = 28'sd131071;
  localparam logic signed [ACC_W-1:0] ACC_QMIN  = -28'sd131072;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [Q_W-1:0] x);
    return {{(ACC_W - Q_W){x[Q_W-1]}}, x};
  endfunction

  function automatic logic signed [Q_W-1:0] sat18(input logic signed [ACC_W-1:0] x);
    logic signed [Q_W-1:0] r;
    if (x > ACC_QMAX) begin
      r = Q_MAX;
    end else if (x < ACC_QMIN) begin
      r = Q_MIN;
    end else begin
      r = x[Q_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mult18s_reg.sv
// 18x18 signed multiplier with a registered 36-bit product, shared by every
// multiply of the neuron update.
module mult18s_reg
  import neuron_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [Q_W-1:0]    op_a,
  input  logic signed [Q_W-1:0]    op_b,
  output logic signed [PROD_W-1:0] prod
);

  // Product register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
    end else begin
      prod <= PROD_W'(op_a) * PROD_W'(op_b);
    end
  end

endmodule

// File: rtl/izh_neuron_fsm.sv
// Izhikevich membrane update: one forward-Euler step of v and u per accepted
// step strobe, using a single time-multiplexed registered multiplier.
module izh_neuron_fsm
  import neuron_pkg::*;
#(
  parameter logic signed [Q_W-1:0]   K_004 = DEF_K_004,
  parameter logic signed [Q_W-1:0]   K_A   = DEF_K_A,
  parameter logic signed [Q_W-1:0]   K_B   = DEF_K_B,
  parameter logic signed [Q_W-1:0]   V_C   = DEF_V_C,
  parameter logic signed [Q_W-1:0]   U_D   = DEF_U_D,
  parameter logic signed [Q_W-1:0]   V_TH  = DEF_V_TH,
  parameter logic signed [ACC_W-1:0] K_140 = DEF_K_140
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  step,
  input  logic signed [Q_W-1:0] i_in,
  output logic signed [Q_W-1:0] v_out,
  output logic signed [Q_W-1:0] u_out,
  output logic                  spike,
  output logic                  done,
  output logic                  busy
);

  state_e                   state_r, state_next_s;
  logic signed [Q_W-1:0]    v_r, v_next_s, u_r, u_next_s;
  logic signed [Q_W-1:0]    i_r, i_next_s, du_r, du_next_s;
  logic signed [ACC_W-1:0]  acc_r, acc_next_s;
  logic                     spike_r, spike_next_s, done_r, done_next_s;
  logic                     busy_r, busy_next_s;

  logic signed [Q_W-1:0]    mul_a_s, mul_b_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  p_q_s, v5_s, acc_calc_s, bvu_diff_s;
  logic signed [ACC_W-1:0]  v_sum_s, u_sum_s, u_kick_s;
  logic signed [Q_W-1:0]    bvu_s, vn_s, un_s, ukn_s;

  mult18s_reg u_mult (
    .clk   (clk),
    .reset (reset),
    .op_a  (mul_a_s),
    .op_b  (mul_b_s),
    .prod  (prod_s)
  );

  // prod_s always holds the product issued in the previous state, rescaled here.
  assign p_q_s      = ACC_W'(prod_s >>> FRAC_W);
  assign v5_s       = (sext(v_r) <<< 2) + sext(v_r);
  assign acc_calc_s = p_q_s + v5_s + K_140 - sext(u_r) + sext(i_r);
  assign bvu_diff_s = p_q_s - sext(u_r);
  assign bvu_s      = sat18(bvu_diff_s);
  assign v_sum_s    = sext(v_r) + acc_r;
  assign vn_s       = sat18(v_sum_s);
  assign u_sum_s    = sext(u_r) + sext(du_r);
  assign un_s       = sat18(u_sum_s);
  assign u_kick_s   = sext(un_s) + sext(U_D);
  assign ukn_s      = sat18(u_kick_s);
  assign busy_next_s = (state_next_s != ST_IDLE);

  // Sequencing, multiplier operand selection and datapath next values.
  always_comb begin
    state_next_s = state_r;
    mul_a_s      = '0;
    mul_b_s      = '0;
    i_next_s     = i_r;
    acc_next_s   = acc_r;
    du_next_s    = du_r;
    v_next_s     = v_r;
    u_next_s     = u_r;
    done_next_s  = 1'b0;
    spike_next_s = 1'b0;
    if (!enable) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (step) begin
            i_next_s     = i_in;
            mul_a_s      = v_r;
            mul_b_s      = K_004;
            state_next_s = ST_MUL_T;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_MUL_T: begin
          mul_a_s      = p_q_s[Q_W-1:0];
          mul_b_s      = v_r;
          state_next_s = ST_MUL_V;
        end
        ST_MUL_V: begin
          acc_next_s   = acc_calc_s;
          mul_a_s      = v_r;
          mul_b_s      = K_B;
          state_next_s = ST_MUL_B;
        end
        ST_MUL_B: begin
          mul_a_s      = K_A;
          mul_b_s      = bvu_s;
          state_next_s = ST_MUL_A;
        end
        ST_MUL_A: begin
          du_next_s    = p_q_s[Q_W-1:0];
          state_next_s = ST_UPDATE;
        end
        ST_UPDATE: begin
          done_next_s  = 1'b1;
          state_next_s = ST_IDLE;
          if (vn_s >= V_TH) begin
            v_next_s     = V_C;
            u_next_s     = ukn_s;
            spike_next_s = 1'b1;
          end else begin
            v_next_s = vn_s;
            u_next_s = un_s;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      v_r     <= V_C;
      u_r     <= U_RST;
      i_r     <= '0;
      acc_r   <= '0;
      du_r    <= '0;
      spike_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      v_r     <= v_next_s;
      u_r     <= u_next_s;
      i_r     <= i_next_s;
      acc_r   <= acc_next_s;
      du_r    <= du_next_s;
      spike_r <= spike_next_s;
      done_r  <= done_next_s;
      busy_r  <= busy_next_s;
    end
  end

  assign v_out = v_r;
  assign u_out = u_r;
  assign spike = spike_r;
  assign done  = done_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_izh_neuron_fsm.sv
// Scoreboard bench for izh_neuron_fsm: directed cases from the neuron's
// documented behaviour followed by randomized steps against an arithmetic model.
module tb_izh_neuron_fsm;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               step = 1'b0;
  logic signed [17:0] i_in = 18'sd0;
  logic signed [17:0] v_out, u_out;
  logic               spike, done, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    longint v;
    longint u;
    bit     sp;
    int     due;
  } exp_t;

  exp_t   sb_q[$];
  bit     model_valid = 1'b0;
  longint m_v, m_u, m_i;
  bit     m_pend = 1'b0;
  int     m_start = 0;

  izh_neuron_fsm dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .step   (step),
    .i_in   (i_in),
    .v_out  (v_out),
    .u_out  (u_out),
    .spike  (spike),
    .done   (done),
    .busy   (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint clamp18(input longint x);
    if (x > 131071) return 131071;
    else if (x < -131072) return -131072;
    else return x;
  endfunction

  // One explicit-Euler step of the Izhikevich equations in Q8.10 integers.
  function automatic void izh(input longint v, input longint u, input longint i,
                              output longint vn_o, output longint un_o, output bit sp);
    longint t, dv, bv, du, vn, un;
    t  = (v * 41) >>> 10;
    dv = ((t * v) >>> 10) + 5 * v + 140 * 1024 - u + i;
    bv = (v * 205) >>> 10;
    du = (20 * clamp18(bv - u)) >>> 10;
    vn = clamp18(v + dv);
    un = clamp18(u + du);
    if (vn >= 30720) begin
      vn_o = -66560;
      un_o = clamp18(un + 8192);
      sp   = 1'b1;
    end else begin
      vn_o = vn;
      un_o = un;
      sp   = 1'b0;
    end
  endfunction

  task automatic expect_val(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Check the visible state against the model, then apply one cycle of inputs.
  task automatic drive(input bit rst, input bit en, input bit stp, input longint iv);
    longint nv, nu;
    bit     sp;
    @(negedge clk);
    if (model_valid) begin
      expect_val("busy", longint'(busy), longint'(m_pend));
      expect_val("v_out", longint'(v_out), m_v);
      expect_val("u_out", longint'(u_out), m_u);
    end
    reset  = rst;
    enable = en;
    step   = stp;
    i_in   = 18'(iv);
    if (rst) begin
      m_v = -66560; m_u = -13312; m_pend = 1'b0; model_valid = 1'b1;
    end else if (!en) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (cyc == m_start + 5) begin
        izh(m_v, m_u, m_i, nv, nu, sp);
        sb_q.push_back('{v: nv, u: nu, sp: sp, due: m_start + 6});
        m_v = nv; m_u = nu; m_pend = 1'b0;
      end
    end else if (stp) begin
      m_pend = 1'b1; m_start = cyc; m_i = iv;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    idle(1);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (model_valid) begin
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        e = sb_q.pop_front();
        expect_val("done_missing", longint'(cyc), longint'(e.due));
      end
      expect_val("spike_without_done", longint'(spike & ~done), 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          expect_val("done_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          expect_val("done_cycle", longint'(cyc), longint'(e.due));
          expect_val("done_v", longint'(v_out), e.v);
          expect_val("done_u", longint'(u_out), e.u);
          expect_val("done_spike", longint'(spike), longint'(e.sp));
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    expect_val("rst_v", longint'(v_out), -66560);
    expect_val("rst_u", longint'(u_out), -13312);
    expect_val("rst_spike", longint'(spike), 0);
    expect_val("rst_done", longint'(done), 0);
    expect_val("rst_busy", longint'(busy), 0);

    // Single sub-threshold step
    drive(1'b0, 1'b1, 1'b1, 0);
    idle(6);
    expect_val("single_done", longint'(done), 1);
    expect_val("single_v", longint'(v_out), -69463);
    expect_val("single_u", longint'(u_out), -13313);
    expect_val("single_spike", longint'(spike), 0);

    // Supra-threshold step fires and resets
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 131071);
    idle(6);
    expect_val("supra_done", longint'(done), 1);
    expect_val("supra_spike", longint'(spike), 1);
    expect_val("supra_v", longint'(v_out), -66560);
    expect_val("supra_u", longint'(u_out), -5121);

    // Step while busy is dropped; step on the done cycle is accepted
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 0);
    idle(1);
    drive(1'b0, 1'b1, 1'b1, 0);
    idle(3);
    drive(1'b0, 1'b1, 1'b1, 0);
    expect_val("busy_step_done", longint'(done), 1);
    expect_val("busy_step_v", longint'(v_out), -69463);
    idle(6);
    expect_val("second_done", longint'(done), 1);

    // Abort by dropping enable, then a clean step
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 0);
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    expect_val("abort_busy", longint'(busy), 0);
    expect_val("abort_v", longint'(v_out), -66560);
    idle(4);
    drive(1'b0, 1'b1, 1'b1, 0);
    idle(6);
    expect_val("after_abort_v", longint'(v_out), -69463);
    expect_val("after_abort_u", longint'(u_out), -13313);

    // Reset in the middle of an update
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 0);
    idle(3);
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    expect_val("midrst_busy", longint'(busy), 0);
    expect_val("midrst_v", longint'(v_out), -66560);
    expect_val("midrst_u", longint'(u_out), -13312);
    expect_val("midrst_done", longint'(done), 0);
    idle(6);

    // Randomized currents, steps, enable drops and occasional resets
    for (int n = 0; n < 3000; n++) begin
      longint iv;
      bit     rst, en, stp;
      if ($urandom_range(0, 3) == 0) iv = longint'($urandom_range(0, 262143)) - 131072;
      else iv = longint'($urandom_range(0, 25600)) - 5120;
      rst = ($urandom_range(0, 499) == 0);
      en  = ($urandom_range(0, 39) != 0);
      stp = ($urandom_range(0, 2) != 0);
      drive(rst, en, stp, iv);
    end
    idle(8);
    expect_val("sb_drain", longint'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
